// File: rtl/fir_coeff_ctrl_if.sv
// fir_coeff_ctrl_if: coefficient configuration port and active-bank outputs of the FIR coefficient controller
interface fir_coeff_ctrl_if #(
  parameter int TAPS        = 8,
  parameter int COEFF_WIDTH = 16
);
  logic                        cfg_wr_en;
  logic [$clog2(TAPS)-1:0]     cfg_addr;
  logic [COEFF_WIDTH-1:0]      cfg_data;
  logic                        cfg_commit;
  logic                        frame_sync;
  logic [TAPS*COEFF_WIDTH-1:0] coeffs_flat;
  logic                        dout_valid;
  logic                        cfg_busy;
  logic                        cfg_err;
  logic [7:0]                  coef_gen;
  modport master (
    output cfg_wr_en, cfg_addr, cfg_data, cfg_commit, frame_sync,
    input  coeffs_flat, dout_valid, cfg_busy, cfg_err, coef_gen
  );
  modport slave (
    input  cfg_wr_en, cfg_addr, cfg_data, cfg_commit, frame_sync,
    output coeffs_flat, dout_valid, cfg_busy, cfg_err, coef_gen
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: shadow/active coefficient banks with frame-aligned atomic swap and post-swap output blanking
module fir_coeff_ctrl #(
  parameter int TAPS         = 8,
  parameter int COEFF_WIDTH  = 16,
  parameter int FLUSH_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_coeff_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;
  typedef logic [TAPS-1:0][COEFF_WIDTH-1:0] bank_t;
  state_t           state_q, state_d;
  bank_t            shadow_q, shadow_d, active_q, active_d;
  logic [7:0]       gen_q, gen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d, err_q, err_d, wr_ok;
  // the shadow is frozen only while a commit waits for its frame boundary
  assign wr_ok = bus.cfg_wr_en && state_q != PENDING;
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    gen_d    = gen_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    if (wr_ok) shadow_d[bus.cfg_addr] = bus.cfg_data;
    err_d = (state_q == PENDING && (bus.cfg_wr_en || bus.cfg_commit)) ||
            (state_q == FLUSH && bus.cfg_commit);
    case (state_q)
      IDLE:    state_d = bus.cfg_commit ? PENDING : IDLE;
      PENDING: if (bus.frame_sync) begin
        active_d = shadow_q;
        gen_d    = gen_q + 8'd1;
        valid_d  = 1'b0;
        cnt_d    = CNT_W'(FLUSH_CYCLES);
        state_d  = FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      gen_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      gen_q    <= gen_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end
  assign bus.coeffs_flat = active_q;
  assign bus.dout_valid  = valid_q;
  assign bus.cfg_busy    = state_q != IDLE;
  assign bus.cfg_err     = err_q;
  assign bus.coef_gen    = gen_q;
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: directed bench with a reference model; expected banks queued at commit, popped at swap
module tb_fir_coeff_ctrl;
  localparam int TAPS = 8;
  localparam int CW   = 16;
  localparam int FC   = 5;
  typedef logic [TAPS-1:0][CW-1:0] bank_t;
  typedef enum {M_IDLE, M_PEND, M_FLUSH} mst_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fir_coeff_ctrl_if #(.TAPS(TAPS), .COEFF_WIDTH(CW)) bus ();
  fir_coeff_ctrl #(.TAPS(TAPS), .COEFF_WIDTH(CW), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int n_assert = 0;
  int n_fail   = 0;
  mst_t       m_st;
  bank_t      m_sh, m_act;
  logic [7:0] m_gen;
  int         m_cnt;
  logic       m_valid, m_err;
  bank_t      exp_q[$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_st = M_IDLE; m_sh = '0; m_act = '0; m_gen = '0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_coeffs"}, bus.coeffs_flat, '0);
    chk({tag, "_busy"}, bus.cfg_busy, 0);
    chk({tag, "_valid"}, bus.dout_valid, 0);
    chk({tag, "_err"}, bus.cfg_err, 0);
    chk({tag, "_gen"}, bus.coef_gen, 0);
  endtask
  // advance the model on the currently driven inputs, clock once, compare every output
  task automatic cyc();
    m_err = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (bus.cfg_wr_en) m_sh[bus.cfg_addr] = bus.cfg_data;
        if (bus.cfg_commit) begin
          exp_q.push_back(m_sh);
          m_st = M_PEND;
        end
      end
      M_PEND: begin
        m_err = bus.cfg_wr_en | bus.cfg_commit;
        if (bus.frame_sync) begin
          chk("sb_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) m_act = exp_q.pop_front();
          m_gen++;
          m_valid = 1'b0;
          m_cnt = FC;
          m_st = M_FLUSH;
        end
      end
      default: begin
        if (bus.cfg_wr_en) m_sh[bus.cfg_addr] = bus.cfg_data;
        m_err = bus.cfg_commit;
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_st = M_IDLE;
        end
      end
    endcase
    @(posedge clk);
    #1;
    chk("coeffs", bus.coeffs_flat, m_act);
    chk("busy", bus.cfg_busy, m_st != M_IDLE);
    chk("valid", bus.dout_valid, m_valid);
    chk("err", bus.cfg_err, m_err);
    chk("gen", bus.coef_gen, m_gen);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic c = 1'b0);
    bus.cfg_wr_en = 1'b1; bus.cfg_addr = a; bus.cfg_data = d; bus.cfg_commit = c;
    cyc();
    bus.cfg_wr_en = 1'b0; bus.cfg_commit = 1'b0;
  endtask
  task automatic commit();
    bus.cfg_commit = 1'b1;
    cyc();
    bus.cfg_commit = 1'b0;
  endtask
  task automatic sync();
    bus.frame_sync = 1'b1;
    cyc();
    bus.frame_sync = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.cfg_busy && n < 30) begin
      cyc();
      n++;
    end
    chk("busy_timeout", bus.cfg_busy, 0);
  endtask
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    m_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk_zero("post_rst");
  endtask
  logic [15:0] tv [8] = '{16'h000A, 16'h0019, 16'h0032, 16'h004B, 16'h004B, 16'h0032, 16'h0019, 16'h000A};
  initial begin
    int n;
    bus.cfg_wr_en = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0; bus.frame_sync = 1'b0;
    m_reset();
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) wr(3'(k), tv[k]);
    commit();
    idle(1);
    sync();
    chk("t1_coeffs", bus.coeffs_flat, 128'h000A_0019_0032_004B_004B_0032_0019_000A);
    chk("t1_gen", bus.coef_gen, 1);
    n = 0;
    while (!bus.dout_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("t1_valid_latency", n, FC);
    commit();
    idle(20);
    chk("t2_gen_held", bus.coef_gen, 1);
    sync();
    chk("t2_gen", bus.coef_gen, 2);
    wait_idle();
    commit();
    wr(3, 16'h7FFF);
    chk("t3_wr_err", bus.cfg_err, 1);
    idle(1);
    sync();
    chk("t3_tap3", bus.coeffs_flat[3*CW +: CW], 16'h004B);
    commit();
    chk("t3_commit_err", bus.cfg_err, 1);
    chk("t3_gen", bus.coef_gen, 3);
    wait_idle();
    wr(5, 16'h8000, 1'b1);
    sync();
    chk("t4_tap5", bus.coeffs_flat[5*CW +: CW], 16'h8000);
    chk("t4_gen", bus.coef_gen, 4);
    wait_idle();
    repeat (251) begin
      commit();
      sync();
      wait_idle();
    end
    chk("t5_gen255", bus.coef_gen, 255);
    commit();
    sync();
    wr(0, 16'h1234);
    chk("t5_gen_wrap", bus.coef_gen, 0);
    chk("t5_tap0_old", bus.coeffs_flat[0 +: CW], 16'h000A);
    wait_idle();
    commit();
    sync();
    chk("t5_tap0_new", bus.coeffs_flat[0 +: CW], 16'h1234);
    wait_idle();
    commit();
    sync();
    idle(2);
    async_reset();
    idle(8);
    commit();
    sync();
    chk("t6_coeffs", bus.coeffs_flat, '0);
    chk("t6_gen", bus.coef_gen, 1);
    wait_idle();
    chk("t6_valid", bus.dout_valid, 1);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient configuration controller for the pipelined parallel FIR filter. It takes single-coefficient writes into a shadow bank, commits the whole set atomically on a frame boundary, and drives the active coefficient bus into the filter's multiplier stage. After each swap it blanks the output-valid flag until the adder tree holds only new-coefficient products. It lets coefficients be retuned at run time without glitched mixed-set outputs.

## Interface
- TAPS, 8, number of coefficients; power of 2, ≥2
- COEFF_WIDTH, 16, signed coefficient width
- FLUSH_CYCLES, 5, cycles of output blanking after a swap; equals 2 + log2(TAPS) for the filter pipeline
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_wr_en  in  1  write strobe for one shadow coefficient
- cfg_addr  in  log2(TAPS)  tap index to write
- cfg_data  in  COEFF_WIDTH  signed coefficient value
- cfg_commit  in  1  request atomic swap of shadow to active
- frame_sync  in  1  frame boundary strobe; a swap occurs only on this
- coeffs_flat  out  TAPS*COEFF_WIDTH  active bank; tap k at bits [k*COEFF_WIDTH +: COEFF_WIDTH]
- dout_valid  out  1  filter output is computed entirely with one coefficient set
- cfg_busy  out  1  high in PENDING and FLUSH
- cfg_err  out  1  one-cycle pulse on a rejected write or commit
- coef_gen  out  8  swap counter; wraps 255→0

## Operation
- States: IDLE, PENDING, FLUSH. Reset state is IDLE.
- Reset values: shadow = 0, active = 0, coeffs_flat = 0, dout_valid = 0, cfg_busy = 0, cfg_err = 0, coef_gen = 0, flush counter = 0.
- Reset asserted mid-operation returns every register to its reset value, including any pending commit.
- IDLE
  - cfg_wr_en writes cfg_data into shadow[cfg_addr].
  - cfg_commit → PENDING.
  - A write and a commit in the same cycle: the write lands in the shadow and is included in the commit.
  - Commit with no prior writes is legal and re-swaps the current shadow.
- PENDING
  - Writes are rejected: shadow unchanged, cfg_err pulses.
  - Commits are rejected: cfg_err pulses.
  - On the first cycle in PENDING with frame_sync = 1:
    - active ← shadow (all TAPS simultaneously)
    - coef_gen increments
    - dout_valid ← 0
    - flush counter ← FLUSH_CYCLES
    - → FLUSH
  - frame_sync in the same cycle as the commit that enters PENDING does not trigger the swap.
- FLUSH
  - Counter decrements each cycle. At 1 → 0: dout_valid ← 1, → IDLE.
  - Writes are accepted, because the shadow is already copied.
  - Commits are rejected with a cfg_err pulse.
  - frame_sync is ignored.
- dout_valid stays 0 from reset until the first swap's flush completes.
- Writes and commits never alter active except at the swap.
- cfg_err is registered. If both a write and a commit are rejected in the same cycle, cfg_err is a single pulse.

## Timing
- Commit at edge c:
  - cfg_busy = 1 after edge c.
  - Swap occurs at the first edge e > c where frame_sync = 1 is sampled.
  - coeffs_flat and coef_gen update after edge e.
- dout_valid:
  - Falls after edge e.
  - Rises after edge e + FLUSH_CYCLES.
  - cfg_busy falls at that same edge.
- Minimum commit-to-valid time is FLUSH_CYCLES + 1 cycles.
- A write accepted at edge w is visible in the shadow after edge w.
- Single-cycle throughput: one write per cycle in IDLE and FLUSH.

## Test plan
- Reset, then write taps 0..7 = 0x000A,0x0019,0x0032,0x004B,0x004B,0x0032,0x0019,0x000A, commit, frame_sync two cycles later → coeffs_flat matches exactly, coef_gen = 1, dout_valid rises 5 cycles after the swap edge.
- Commit with frame_sync low for 20 cycles → coeffs_flat unchanged, cfg_busy = 1 throughout. Then frame_sync pulse → swap on that edge.
- Write tap 3 = 0x7FFF while PENDING → cfg_err pulses 1 cycle, swapped tap 3 keeps the pre-commit value. Commit in FLUSH → cfg_err pulses, coef_gen unchanged.
- Write tap 5 = 0x8000 and cfg_commit in the same cycle, frame_sync next cycle → active tap 5 = 0x8000.
- 256 commit/swap sequences → coef_gen wraps to 0. Write during FLUSH is accepted and appears only after the next swap.
- Assert rst_n low during FLUSH after a swap → all outputs 0 asynchronously, state IDLE, dout_valid stays 0 until the next completed swap.
